// File: rtl/bus_data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// bus_data_mem_responder_if
// Data-bus bundle between the core's bus master port and the memory
// responder.
//   busSel       master -> slave  request strobe
//   busWe        master -> slave  1 = write, 0 = read
//   busAddr      master -> slave  byte address (bits [1:0] ignored by slave)
//   busWData     master -> slave  lane-aligned write data
//   Byte_Enable  master -> slave  write lane enables
//   busRData     slave -> master  read data, valid with busReady
//   busReady     slave -> master  one-cycle completion pulse
//   busError     slave -> master  out-of-window flag, valid with busReady
// ---------------------------------------------------------------------------
interface bus_data_mem_responder_if;
    logic        busSel;
    logic        busWe;
    logic [31:0] busAddr;
    logic [31:0] busWData;
    logic [3:0]  Byte_Enable;
    logic [31:0] busRData;
    logic        busReady;
    logic        busError;

    modport master (
        output busSel, busWe, busAddr, busWData, Byte_Enable,
        input  busRData, busReady, busError
    );

    modport slave (
        input  busSel, busWe, busAddr, busWData, Byte_Enable,
        output busRData, busReady, busError
    );
endinterface

// File: rtl/bus_data_mem_responder.sv
// ---------------------------------------------------------------------------
// bus_data_mem_responder
// Memory-side responder for the core's data bus. Captures a request in IDLE,
// waits WAIT_CYCLES extra cycles, performs the byte-enabled write or full
// word read against a word RAM mapped at BASE_ADDR, and pulses busReady for
// one cycle (with busError for out-of-window addresses).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset (control and outputs; RAM kept)
//   bus    slave side of bus_data_mem_responder_if
// ---------------------------------------------------------------------------
module bus_data_mem_responder #(
    parameter int          ADDR_WIDTH  = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    bus_data_mem_responder_if.slave   bus
);

    localparam int         DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;

    // Captured request; the byte offset bits are never needed.
    logic        r_we;
    logic [31:2] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;

    logic [31:0] r_mem [0:DEPTH-1];
    logic [31:0] r_rdata;
    logic        r_ready;
    logic        r_error;

    logic                  w_capture;
    logic                  w_cnt_inc;
    logic                  w_access;
    logic                  w_in_win;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_unused_addr_lsb;

    assign w_unused_addr_lsb = ^bus.busAddr[1:0];

    assign w_in_win = (r_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign w_idx    = r_addr[ADDR_WIDTH+1:2];

    // Next-state and per-cycle control decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_access    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.busSel) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == LP_WAIT) begin
                    w_access    = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_ready <= 1'b0;
            r_error <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_cnt <= 4'd0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 4'd1;
            end
            // Ready/error only live for the RESP cycle after the access edge.
            r_ready <= w_access;
            r_error <= w_access & ~w_in_win;
            if (w_access && !r_we) begin
                r_rdata <= w_in_win ? r_mem[w_idx] : 32'd0;
            end
        end
    end

    // Request capture; data path only, so no reset.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_we    <= bus.busWe;
            r_addr  <= bus.busAddr[31:2];
            r_wdata <= bus.busWData;
            r_be    <= bus.Byte_Enable;
        end
    end

    // RAM write; reset at the access edge aborts the write.
    always_ff @(posedge clk) begin
        if (w_access && r_we && w_in_win && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.busRData = r_rdata;
    assign bus.busReady = r_ready;
    assign bus.busError = r_error;

endmodule

// File: tb/tb_bus_data_mem_responder.sv
module tb_bus_data_mem_responder;

    localparam int          AW        = 8;
    localparam logic [31:0] BASE      = 32'h1000_0000;
    localparam logic [31:0] WIN_BYTES = 32'd1024;
    localparam int          WS [4]    = '{0, 1, 3, 15};
    localparam int          MAIN      = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  be = 4'd0;

    logic [3:0]  rdy;
    logic [3:0]  err_v;
    logic [31:0] rd_v [4];

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model state
    logic [31:0] ref_mem [0:255];
    logic [31:0] ref_rd = 32'd0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        bus_data_mem_responder_if bus ();
        assign bus.busSel      = sel;
        assign bus.busWe       = we;
        assign bus.busAddr     = addr;
        assign bus.busWData    = wdata;
        assign bus.Byte_Enable = be;
        assign rdy[g]          = bus.busReady;
        assign err_v[g]        = bus.busError;
        assign rd_v[g]         = bus.busRData;

        bus_data_mem_responder #(
            .ADDR_WIDTH (AW),
            .BASE_ADDR  (BASE),
            .WAIT_CYCLES(WS[g])
        ) u_dut (
            .clk  (clk),
            .reset(rst),
            .bus  (bus)
        );
    end

    // Behavioural memory: window test by offset arithmetic, lanes by mask.
    function automatic void model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                                         input logic [3:0] b, output logic [31:0] erd, output logic eerr);
        logic [31:0] off;
        int idx;
        off  = a - BASE;
        eerr = !(off < WIN_BYTES);
        idx  = int'(off >> 2);
        if (!eerr) begin
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
            end else begin
                ref_rd = ref_mem[idx];
            end
        end else if (!w) begin
            ref_rd = 32'd0;
        end
        erd = ref_rd;
    endfunction

    // Drives one request on the main DUT and reports what it observed.
    task automatic do_access(input logic we_i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                             output logic [31:0] rd, output logic er, output int lat, output logic rdy_after);
        @(negedge clk);
        we = we_i; addr = a; wdata = d; be = b; sel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sel = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            if (rdy[MAIN]) begin
                lat = c;
                break;
            end
        end
        rd = rd_v[MAIN];
        er = err_v[MAIN];
        @(negedge clk);
        rdy_after = rdy[MAIN];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (rdy[k] !== 1'b0 || err_v[k] !== 1'b0 || rd_v[k] !== 32'd0)
                $display("FAIL reset_out[%0d] got rdy=%b err=%b rd=%h want 0 0 0", k, rdy[k], err_v[k], rd_v[k]);
            else pass_cnt++;
        end
        rst = 1'b0;
        ref_rd = 32'd0;
    endtask

    task automatic test_word_rw();
        logic [31:0] rd, erd; logic er, eer, ra; int lat;
        do_access(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'b1111, rd, er, lat, ra);
        model_access(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'b1111, erd, eer);
        total_cnt++;
        if (lat !== 3 || ra !== 1'b0 || er !== 1'b0)
            $display("FAIL word_write got lat=%0d after=%b err=%b want 3 0 0", lat, ra, er);
        else pass_cnt++;
        do_access(1'b0, 32'h1000_0010, 32'h0, 4'b0000, rd, er, lat, ra);
        model_access(1'b0, 32'h1000_0010, 32'h0, 4'b0000, erd, eer);
        total_cnt++;
        if (lat !== 3 || ra !== 1'b0 || er !== 1'b0 || rd !== 32'hDEAD_BEEF)
            $display("FAIL word_read got lat=%0d after=%b err=%b rd=%h want 3 0 0 deadbeef", lat, ra, er, rd);
        else pass_cnt++;
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd, erd; logic er, eer, ra; int lat;
        do_access(1'b1, 32'h1000_0010, 32'h0000_5A00, 4'b0010, rd, er, lat, ra);
        model_access(1'b1, 32'h1000_0010, 32'h0000_5A00, 4'b0010, erd, eer);
        do_access(1'b0, 32'h1000_0010, 32'h0, 4'b0000, rd, er, lat, ra);
        model_access(1'b0, 32'h1000_0010, 32'h0, 4'b0000, erd, eer);
        total_cnt++;
        if (rd !== 32'hDEAD_5AEF) $display("FAIL lane1_read got %h want dead5aef", rd);
        else pass_cnt++;
        do_access(1'b1, 32'h1000_0010, 32'h1234_0000, 4'b1100, rd, er, lat, ra);
        model_access(1'b1, 32'h1000_0010, 32'h1234_0000, 4'b1100, erd, eer);
        do_access(1'b0, 32'h1000_0011, 32'h0, 4'b0001, rd, er, lat, ra);
        model_access(1'b0, 32'h1000_0011, 32'h0, 4'b0001, erd, eer);
        total_cnt++;
        if (rd !== 32'h1234_5AEF) $display("FAIL lane23_read got %h want 12345aef", rd);
        else pass_cnt++;
        // Zero-enable write still completes and changes nothing.
        do_access(1'b1, 32'h1000_0010, 32'hFFFF_FFFF, 4'b0000, rd, er, lat, ra);
        model_access(1'b1, 32'h1000_0010, 32'hFFFF_FFFF, 4'b0000, erd, eer);
        total_cnt++;
        if (lat !== 3 || er !== 1'b0) $display("FAIL be0_write got lat=%0d err=%b want 3 0", lat, er);
        else pass_cnt++;
        do_access(1'b0, 32'h1000_0010, 32'h0, 4'b0000, rd, er, lat, ra);
        model_access(1'b0, 32'h1000_0010, 32'h0, 4'b0000, erd, eer);
        total_cnt++;
        if (rd !== 32'h1234_5AEF) $display("FAIL be0_read got %h want 12345aef", rd);
        else pass_cnt++;
    endtask

    task automatic test_out_of_window();
        logic [31:0] rd, erd; logic er, eer, ra; int lat;
        do_access(1'b1, 32'h1000_0000, 32'hCAFE_F00D, 4'b1111, rd, er, lat, ra);
        model_access(1'b1, 32'h1000_0000, 32'hCAFE_F00D, 4'b1111, erd, eer);
        do_access(1'b0, 32'h2000_0000, 32'h0, 4'b0000, rd, er, lat, ra);
        model_access(1'b0, 32'h2000_0000, 32'h0, 4'b0000, erd, eer);
        total_cnt++;
        if (lat !== 3 || er !== 1'b1 || rd !== 32'd0)
            $display("FAIL oow_read got lat=%0d err=%b rd=%h want 3 1 0", lat, er, rd);
        else pass_cnt++;
        do_access(1'b1, 32'h1000_0400, 32'h0BAD_BAD0, 4'b1111, rd, er, lat, ra);
        model_access(1'b1, 32'h1000_0400, 32'h0BAD_BAD0, 4'b1111, erd, eer);
        total_cnt++;
        if (lat !== 3 || er !== 1'b1) $display("FAIL oow_write got lat=%0d err=%b want 3 1", lat, er);
        else pass_cnt++;
        do_access(1'b0, 32'h1000_0000, 32'h0, 4'b0000, rd, er, lat, ra);
        model_access(1'b0, 32'h1000_0000, 32'h0, 4'b0000, erd, eer);
        total_cnt++;
        if (er !== 1'b0 || rd !== 32'hCAFE_F00D)
            $display("FAIL word0_intact got err=%b rd=%h want 0 cafef00d", er, rd);
        else pass_cnt++;
        // Edges of the window.
        do_access(1'b1, 32'h1000_03FC, 32'h5555_AAAA, 4'b1111, rd, er, lat, ra);
        model_access(1'b1, 32'h1000_03FC, 32'h5555_AAAA, 4'b1111, erd, eer);
        do_access(1'b0, 32'h1000_03FC, 32'h0, 4'b0000, rd, er, lat, ra);
        model_access(1'b0, 32'h1000_03FC, 32'h0, 4'b0000, erd, eer);
        total_cnt++;
        if (er !== 1'b0 || rd !== 32'h5555_AAAA)
            $display("FAIL top_word got err=%b rd=%h want 0 5555aaaa", er, rd);
        else pass_cnt++;
        do_access(1'b0, 32'h0FFF_FFFC, 32'h0, 4'b0000, rd, er, lat, ra);
        model_access(1'b0, 32'h0FFF_FFFC, 32'h0, 4'b0000, erd, eer);
        total_cnt++;
        if (er !== 1'b1 || rd !== 32'd0)
            $display("FAIL below_base got err=%b rd=%h want 1 0", er, rd);
        else pass_cnt++;
    endtask

    task automatic test_wait_sweep();
        int first [4]; int nr [4];
        logic [31:0] rd, erd, held; logic er, eer, ra; int lat;
        sel = 1'b0;
        repeat (25) @(negedge clk);
        for (int k = 0; k < 4; k++) begin first[k] = -1; nr[k] = 0; end
        @(negedge clk);
        we = 1'b0; addr = 32'h1000_0010; be = 4'b0000; sel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sel = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            if (c > 1) @(negedge clk);
            for (int k = 0; k < 4; k++)
                if (rdy[k] === 1'b1) begin
                    if (first[k] < 0) first[k] = c;
                    nr[k]++;
                end
        end
        model_access(1'b0, 32'h1000_0010, 32'h0, 4'b0000, erd, eer);
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (first[k] != WS[k] + 2 || nr[k] != 1)
                $display("FAIL sweep_w%0d got first=%0d width=%0d want %0d 1", WS[k], first[k], nr[k], WS[k] + 2);
            else pass_cnt++;
        end
        total_cnt++;
        if (rd_v[MAIN] !== 32'h1234_5AEF) $display("FAIL sweep_rdata got %h want 12345aef", rd_v[MAIN]);
        else pass_cnt++;
        // Read data survives a following write.
        held = rd_v[MAIN];
        do_access(1'b1, 32'h1000_0010, 32'h7777_7777, 4'b1111, rd, er, lat, ra);
        model_access(1'b1, 32'h1000_0010, 32'h7777_7777, 4'b1111, erd, eer);
        total_cnt++;
        if (rd !== held || rd_v[MAIN] !== held)
            $display("FAIL rdata_hold got %h/%h want %h", rd, rd_v[MAIN], held);
        else pass_cnt++;
    endtask

    task automatic test_held_sel();
        int c1, c2;
        logic [31:0] rd, erd; logic er, eer, ra; int lat;
        c1 = -1; c2 = -1;
        @(negedge clk);
        we = 1'b1; addr = 32'h1000_0030; wdata = 32'hA1A1_A1A1; be = 4'b1111; sel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        addr = 32'h1000_0034; wdata = 32'hB2B2_B2B2;
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) @(negedge clk);
            if (rdy[MAIN] === 1'b1) begin
                if (c1 < 0) c1 = c;
                else begin c2 = c; break; end
            end
        end
        sel = 1'b0;
        model_access(1'b1, 32'h1000_0030, 32'hA1A1_A1A1, 4'b1111, erd, eer);
        model_access(1'b1, 32'h1000_0034, 32'hB2B2_B2B2, 4'b1111, erd, eer);
        total_cnt++;
        if (c1 != 3 || c2 != 7) $display("FAIL held_sel got ready at %0d,%0d want 3,7", c1, c2);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        do_access(1'b0, 32'h1000_0030, 32'h0, 4'b0000, rd, er, lat, ra);
        model_access(1'b0, 32'h1000_0030, 32'h0, 4'b0000, erd, eer);
        total_cnt++;
        if (rd !== 32'hA1A1_A1A1) $display("FAIL captured_addr got %h want a1a1a1a1", rd);
        else pass_cnt++;
        do_access(1'b0, 32'h1000_0034, 32'h0, 4'b0000, rd, er, lat, ra);
        model_access(1'b0, 32'h1000_0034, 32'h0, 4'b0000, erd, eer);
        total_cnt++;
        if (rd !== 32'hB2B2_B2B2) $display("FAIL second_access got %h want b2b2b2b2", rd);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, erd; logic er, eer, ra; int lat;
        do_access(1'b1, 32'h1000_0020, 32'h1122_3344, 4'b1111, rd, er, lat, ra);
        model_access(1'b1, 32'h1000_0020, 32'h1122_3344, 4'b1111, erd, eer);
        do_access(1'b0, 32'h1000_0010, 32'h0, 4'b0000, rd, er, lat, ra);
        model_access(1'b0, 32'h1000_0010, 32'h0, 4'b0000, erd, eer);
        @(negedge clk);
        we = 1'b1; addr = 32'h1000_0020; wdata = 32'hFFFF_FFFF; be = 4'b1111; sel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sel = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (rdy[MAIN] !== 1'b0 || err_v[MAIN] !== 1'b0 || rd_v[MAIN] !== 32'd0)
            $display("FAIL mid_reset_out got rdy=%b err=%b rd=%h want 0 0 0", rdy[MAIN], err_v[MAIN], rd_v[MAIN]);
        else pass_cnt++;
        rst = 1'b0;
        ref_rd = 32'd0;
        repeat (20) @(negedge clk);
        do_access(1'b0, 32'h1000_0020, 32'h0, 4'b0000, rd, er, lat, ra);
        model_access(1'b0, 32'h1000_0020, 32'h0, 4'b0000, erd, eer);
        total_cnt++;
        if (lat !== 3 || rd !== 32'h1122_3344) $display("FAIL aborted_write got lat=%0d rd=%h want 3 11223344", lat, rd);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a, d; logic er, eer, ra, w; logic [3:0] b; int lat;
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            do_access(1'b1, BASE + 32'(4 * i), d, 4'b1111, rd, er, lat, ra);
            model_access(1'b1, BASE + 32'(4 * i), d, 4'b1111, erd, eer);
        end
        for (int n = 0; n < 40; n++) begin
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) a = $urandom | 32'h8000_0000;
            else a = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            d = $urandom;
            b = 4'($urandom);
            do_access(w, a, d, b, rd, er, lat, ra);
            model_access(w, a, d, b, erd, eer);
            total_cnt++;
            if (lat !== 3 || ra !== 1'b0 || er !== eer || rd !== erd)
                $display("FAIL rand[%0d] we=%b a=%h got lat=%0d after=%b err=%b rd=%h want 3 0 %b %h",
                         n, w, a, lat, ra, er, rd, eer, erd);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_out_of_window();
        test_wait_sweep();
        test_held_sel();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
